cursor_move_ctrl: RTL
=====================

# cursor_move_ctrl

Sequencing controller for the on-screen character window. Debounces the four raw direction buttons and converts each clean press into one bounded move request. Arbitrates simultaneous requests and owns the window position registers, re-centering the window when the character magnification changes. Feeds window start/end coordinates to the pixel-compare logic of the VGA display path.

## Interface
- `HDT`, default 640: horizontal display width in pixels.
- `VDT`, default 400: vertical display height in lines.
- `HAL`, default 8: unmagnified character width.
- `VAL`, default 16: unmagnified character height.
- `DEB_CYCLES`, default 4: stable cycles required to accept a button level change (≥2).
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `btnUp` / `btnDown` / `btnLeft` / `btnRight`, input, 1 each: raw asynchronous buttons, active-high.
- `charMag`, input, 3: magnification m. Value 0 is treated as 1; values above 4 are clamped to 4.
- `posHorStart`, `posHorEnd`, output, 10: window column start (inclusive) and end (exclusive).
- `posVerStart`, `posVerEnd`, output, 9: window row start (inclusive) and end (exclusive).
- `moveStrobe`, output, 1: one-cycle pulse when a move is committed.
- `blocked`, output, 1: one-cycle pulse when a move is rejected at a screen edge.

## Operation
- **Per-button input conditioning**
  - 2-flop synchronizer produces `s`.
  - Debounced level `deb` and a counter. Counter clears when `s == deb` and increments when `s != deb`.
  - When the counter reaches `DEB_CYCLES-1` with `s != deb`: `deb <= s`, counter clears.
- **Request capture**
  - A rising edge of `deb` sets that direction's bit in a 4-bit `pending` register. Set is OR, so repeats are idempotent.
  - If a bit is set and cleared on the same cycle, the set wins.
  - A held button yields exactly one request. Falling edges are ignored.
- **Step sizes:** hstep = HAL*m, vstep = VAL*m, where `m` is the registered `magReg`. Internal arithmetic is 11-bit unsigned; no negative intermediate values.
- **Centered position:** horStart = (HDT-hstep)/2 and verStart = (VDT-vstep)/2, with integer divide. End = start + step.
- **FSM states: IDLE, CHECK, RECENTER.**
  - IDLE:
    - If clamped `charMag != magReg`, go to RECENTER. This has priority over pending requests.
    - Otherwise, if `pending != 0`, latch the highest-priority direction (up > down > left > right) into `sel` and go to CHECK.
  - CHECK: evaluate `sel` against the bounds below.
    - In bounds: commit the position and pulse `moveStrobe`.
    - Out of bounds: position unchanged, pulse `blocked`.
    - In both cases clear `pending[sel]` and return to IDLE.
  - RECENTER: `magReg <=` clamped `charMag`, position <= centered for the new m, `pending <= 0`, return to IDLE.
- **Bounds** (end is exclusive):
  - up: allowed if verStart ≥ vstep; verStart -= vstep.
  - down: allowed if verStart + 2·vstep ≤ VDT; verStart += vstep.
  - left: allowed if horStart ≥ hstep; horStart -= hstep.
  - right: allowed if horStart + 2·hstep ≤ HDT; horStart += hstep.
- A `charMag` change during CHECK does not abort it. CHECK completes with the old m, then RECENTER runs.

## Timing
- **Reset values:**
  - `magReg` = 1; posHorStart = 316, posHorEnd = 324, posVerStart = 192, posVerEnd = 208 (defaults).
  - `moveStrobe` = 0, `blocked` = 0.
  - state IDLE; `pending`, `deb`, synchronizers and counters = 0.
  - If `charMag` ≠ 1 after reset, RECENTER runs on the first IDLE cycle.
- **Debounce latency:** raw edge to `deb` change is 2 + `DEB_CYCLES` cycles for a stable input. Any bounce restarts the count.
- **Move latency:**
  - `deb` rises in cycle t; `pending` bit visible in t+1 (IDLE); CHECK in t+2.
  - New position and the strobe are visible in t+3, for one cycle.
  - Raw-to-strobe = `DEB_CYCLES` + 5 cycles.
- **Throughput:** one move per 2 cycles; queued requests are serviced back-to-back.
- **Output registering:** outputs are registered. End outputs always equal start + step for the current `magReg`.
- **Reset mid-operation:** reset asserted in any state returns everything to reset values on the next edge. An in-flight CHECK does not commit.

## Test plan
1. **Reset:** assert `reset` 2 cycles → positions 316/324/192/208, both strobes 0, stable for 20 idle cycles.
2. **Right press** (`DEB_CYCLES`=4): `btnRight` high for 20 cycles → one `moveStrobe` exactly 9 cycles after the raw rise, posHorStart = 324, posHorEnd = 332; no second move while held.
3. **Bounce rejection:** `btnLeft` toggles every 2 cycles for 24 cycles, then stays low → no strobe, position unchanged.
4. **Left edge limit:** 40 clean left presses at m=1 → 39 moves to posHorStart = 4; the 40th pulses `blocked` with position unchanged.
5. **Simultaneous press:** `btnUp` and `btnRight` rise on the same cycle → up commits first (posVerStart = 176), right commits 2 cycles later (posHorStart = 324).
6. **Magnification change:** after several moves, set `charMag` = 4 while a left request is pending → RECENTER gives 304/336/168/232, the pending request is dropped, no strobe.

Source files
------------

// File: rtl/cursor_move_ctrl.sv
// Character-window cursor controller.
// Debounces direction buttons and moves or recenters the window.
module cursor_move_ctrl #(
  parameter int HDT = 640,
  parameter int VDT = 400,
  parameter int HAL = 8,
  parameter int VAL = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic [2:0] charMag,
  output logic [9:0] posHorStart,
  output logic [9:0] posHorEnd,
  output logic [8:0] posVerStart,
  output logic [8:0] posVerEnd,
  output logic       moveStrobe,
  output logic       blocked
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [10:0] HDT11 = 11'(HDT);
  localparam logic [10:0] VDT11 = 11'(VDT);
  localparam logic [10:0] HAL11 = 11'(HAL);
  localparam logic [10:0] VAL11 = 11'(VAL);
  localparam logic [9:0] H0 = 10'((HDT - HAL) / 2);
  localparam logic [9:0] H0E = 10'((HDT - HAL) / 2 + HAL);
  localparam logic [8:0] V0 = 9'((VDT - VAL) / 2);
  localparam logic [8:0] V0E = 9'((VDT - VAL) / 2 + VAL);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RECENTER
  } stateT;

  stateT state, stateN;

  logic [3:0] btnRaw;
  logic [3:0] syncA, syncB;
  logic [3:0] deb, debQ, rise;
  logic [CW-1:0] cnt [4];
  logic [3:0] pending, pendClr;
  logic [1:0] sel, selN;
  logic [2:0] magReg, magN, magC;
  logic [10:0] hStep, vStep, hStepC, vStepC;
  logic [10:0] horFull, verFull;
  logic [9:0] horN, horEN;
  logic [8:0] verN, verEN;
  logic strobeN, blockN;

  // bit order: 0 up, 1 down, 2 left, 3 right
  assign btnRaw = {btnRight, btnLeft, btnDown, btnUp};
  assign rise = deb & ~debQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
      deb <= '0;
      debQ <= '0;
      for (int i = 0; i < 4; i++)
        cnt[i] <= '0;
    end else begin
      syncA <= btnRaw;
      syncB <= syncA;
      debQ <= deb;
      for (int i = 0; i < 4; i++) begin
        if (syncB[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= syncB[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    magC = charMag;
    if (charMag == 3'd0)
      magC = 3'd1;
    else if (charMag > 3'd4)
      magC = 3'd4;
  end

  assign hStep = HAL11 * {8'd0, magReg};
  assign vStep = VAL11 * {8'd0, magReg};
  assign hStepC = HAL11 * {8'd0, magC};
  assign vStepC = VAL11 * {8'd0, magC};
  assign horFull = {1'b0, posHorStart};
  assign verFull = {2'b0, posVerStart};

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateN;
  end

  always_comb begin
    stateN = state;
    selN = sel;
    pendClr = '0;
    magN = magReg;
    horN = posHorStart;
    verN = posVerStart;
    strobeN = 1'b0;
    blockN = 1'b0;
    unique case (state)
      IDLE: begin
        if (magC != magReg) begin
          stateN = RECENTER;
        end else if (|pending) begin
          stateN = CHECK;
          priority case (1'b1)
            pending[0]: selN = 2'd0;
            pending[1]: selN = 2'd1;
            pending[2]: selN = 2'd2;
            pending[3]: selN = 2'd3;
          endcase
        end
      end
      CHECK: begin
        stateN = IDLE;
        pendClr[sel] = 1'b1;
        blockN = 1'b1;
        unique case (sel)
          2'd0: if (verFull >= vStep) begin
            verN = 9'(verFull - vStep);
            blockN = 1'b0;
          end
          2'd1: if (verFull + (vStep << 1) <= VDT11) begin
            verN = 9'(verFull + vStep);
            blockN = 1'b0;
          end
          2'd2: if (horFull >= hStep) begin
            horN = 10'(horFull - hStep);
            blockN = 1'b0;
          end
          2'd3: if (horFull + (hStep << 1) <= HDT11) begin
            horN = 10'(horFull + hStep);
            blockN = 1'b0;
          end
        endcase
        strobeN = ~blockN;
      end
      RECENTER: begin
        stateN = IDLE;
        magN = magC;
        horN = 10'((HDT11 - hStepC) >> 1);
        verN = 9'((VDT11 - vStepC) >> 1);
      end
      default: stateN = IDLE;
    endcase
    // ends track the step of the magnification being installed
    if (state == RECENTER) begin
      horEN = 10'({1'b0, horN} + hStepC);
      verEN = 9'({2'b0, verN} + vStepC);
    end else begin
      horEN = 10'({1'b0, horN} + hStep);
      verEN = 9'({2'b0, verN} + vStep);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= '0;
      pending <= '0;
      magReg <= 3'd1;
      posHorStart <= H0;
      posHorEnd <= H0E;
      posVerStart <= V0;
      posVerEnd <= V0E;
      moveStrobe <= 1'b0;
      blocked <= 1'b0;
    end else begin
      sel <= selN;
      magReg <= magN;
      posHorStart <= horN;
      posHorEnd <= horEN;
      posVerStart <= verN;
      posVerEnd <= verEN;
      moveStrobe <= strobeN;
      blocked <= blockN;
      if (state == RECENTER)
        pending <= '0;
      else
        pending <= (pending & ~pendClr) | rise;
    end
  end

endmodule
